lcd_msg_arbiter: RTL and testbench

Shares the single 16x2 LCD message path between up to NREQ test sequencers. Each requester asks for a canned message by ID. The block grants one requester at a time (round-robin) and drives the message-ROM select. It pulses the LCD controller's display-reset input, waits out the 37-cycle write sequence plus a minimum on-screen hold time, then acks the requester.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/lcd_msg_arbiter.sv | 129 ++++++++++++
 tb/tb_lcd_msg_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD message path.
// - state_t        : arbiter FSM state encodings
// - LCD_SEQ_CYCLES : cycles the LCD controller spends outside IDLE per dispres pulse
// - LCD_CMD_*      : command bytes issued by the existing LCD controller
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_ARB   = 3'd0,
      ST_SETUP = 3'd1,
      ST_START = 3'd2,
      ST_WRITE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam int LCD_SEQ_CYCLES = 37;

   localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;  // display on, cursor off
   localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;  // increment, no shift
   localparam logic [7:0] LCD_CMD_HOME       = 8'h02;  // cursor to line 1 col 0
   localparam logic [7:0] LCD_CMD_LINE2      = 8'hC0;  // cursor to line 2 col 0

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req     in  NREQ  request levels
//   ptr     in  PW    highest-priority requester index
//   gnt_oh  out NREQ  one-hot winner (all zero when no request)
//   gnt_idx out PW    winner index
//   any     out 1     at least one request present
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt_oh,
   output logic [PW-1:0]   gnt_idx,
   output logic            any
);

   assign any = |req;

   // Scan from ptr upward with wrap; the first hit wins.
   always_comb begin
      int  j;
      logic found;
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!found && req[j]) begin
            found      = 1'b1;
            gnt_oh[j]  = 1'b1;
            gnt_idx    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Shares the single LCD message path between NREQ requesters.
// One requester at a time is granted (round-robin), its message ID is
// latched onto msg_sel, the LCD controller is kicked with a one-cycle
// dispres pulse, and the requester is acked once the write sequence and
// the minimum on-screen hold time have elapsed.
// Ports:
//   clk      in  1          system clock (shared with the LCD controller)
//   reset    in  1          synchronous, active-high
//   req      in  NREQ       request levels, held until ack
//   msg_id   in  NREQ*MSGW  packed message IDs, requester i at [i*MSGW +: MSGW]
//   ack      out NREQ       one-cycle done pulse to the served requester
//   gnt      out NREQ       one-hot owner, grant through DONE
//   msg_sel  out MSGW       latched ID of the granted message
//   dispres  out 1          one-cycle start pulse to the LCD controller
//   busy     out 1          high whenever not arbitrating
module lcd_msg_arbiter
   import lcd_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int MSGW           = 4,
   parameter int LCD_SEQ_CYCLES = lcd_pkg::LCD_SEQ_CYCLES,
   parameter int HOLD_CYCLES    = 1000,
   parameter int CNTW           = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*MSGW-1:0] msg_id,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      gnt,
   output logic [MSGW-1:0]      msg_sel,
   output logic                 dispres,
   output logic                 busy
);

   localparam int PW = $clog2(NREQ);

   // Counters run from N-1 down to 0, so N cycles are spent in the state.
   localparam logic [CNTW-1:0] SEQ_LD  = CNTW'(LCD_SEQ_CYCLES - 1);
   localparam logic [CNTW-1:0] HOLD_LD = (HOLD_CYCLES == 0) ? '0 : CNTW'(HOLD_CYCLES - 1);

   state_t                     state;
   logic [PW-1:0]              ptr;
   logic [CNTW-1:0]            cnt;
   logic [NREQ-1:0][MSGW-1:0]  ids;
   logic [NREQ-1:0]            pick_oh;
   logic [PW-1:0]              pick_idx;
   logic                       pick_any;

   assign ids = msg_id;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
      .req     (req),
      .ptr     (ptr),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   // Outputs are registered: each is set on the transition into the state
   // in which it must be visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_ARB;
         ack     <= '0;
         gnt     <= '0;
         msg_sel <= '0;
         dispres <= 1'b0;
         busy    <= 1'b0;
         ptr     <= '0;
         cnt     <= '0;
      end else begin
         ack     <= '0;
         dispres <= 1'b0;
         case (state)
            ST_ARB: begin
               if (pick_any) begin
                  gnt     <= pick_oh;
                  msg_sel <= ids[pick_idx];
                  ptr     <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                  busy    <= 1'b1;
                  state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               // ROM/char mux has settled; pulse dispres during START.
               dispres <= 1'b1;
               state   <= ST_START;
            end
            ST_START: begin
               cnt   <= SEQ_LD;
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               if (cnt == '0) begin
                  if (HOLD_CYCLES == 0) begin
                     ack   <= gnt;
                     state <= ST_DONE;
                  end else begin
                     cnt   <= HOLD_LD;
                     state <= ST_HOLD;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  ack   <= gnt;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= ST_ARB;
            end
            default: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= ST_ARB;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Self-checking bench for lcd_msg_arbiter. A transaction-level model
// predicts every output each cycle: a grant decided in ARB cycle c owns
// the path from c+1 to its ack at c+2+SEQ+1+H, with dispres at c+2.
module tb_lcd_msg_arbiter;

   localparam int NREQ = 4;
   localparam int MSGW = 4;
   localparam int SEQ  = 37;
   localparam int H    = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ*MSGW-1:0] msg_id;
   logic [NREQ-1:0]      ack, gnt;
   logic [MSGW-1:0]      msg_sel;
   logic                 dispres, busy;

   logic [NREQ-1:0]      req0;
   logic [NREQ*MSGW-1:0] msg_id0;
   logic [NREQ-1:0]      ack0, gnt0;
   logic [MSGW-1:0]      msg_sel0;
   logic                 dispres0, busy0;

   lcd_msg_arbiter #(.NREQ(NREQ), .MSGW(MSGW), .LCD_SEQ_CYCLES(SEQ), .HOLD_CYCLES(H), .CNTW(16)) dut (
      .clk(clk), .reset(reset), .req(req), .msg_id(msg_id), .ack(ack), .gnt(gnt),
      .msg_sel(msg_sel), .dispres(dispres), .busy(busy));

   lcd_msg_arbiter #(.NREQ(NREQ), .MSGW(MSGW), .LCD_SEQ_CYCLES(SEQ), .HOLD_CYCLES(0), .CNTW(16)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .msg_id(msg_id0), .ack(ack0), .gnt(gnt0),
      .msg_sel(msg_sel0), .dispres(dispres0), .busy(busy0));

   always #5 clk = ~clk;

   int npass = 0, ntot = 0;
   int cyc = 0;

   // reference model state
   bit              m_act = 0;
   int              m_own, m_gs, m_s, m_a;
   int              m_ptr = 0;
   logic [MSGW-1:0] m_msg = '0;
   int              wait_c [NREQ];
   int              glog[$];

   // bench bookkeeping
   bit              auto_rearm = 0;
   logic [NREQ-1:0] rearm = '0;
   int              n_disp = 0, last_disp = -1;
   int              ack_cnt [NREQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
   endtask

   task automatic step();
      int  w;
      bit  in_win;
      logic [NREQ-1:0] e_gnt;
      for (int i = 0; i < NREQ; i++) if (!req[i]) wait_c[i] = 0;
      if (reset) begin
         m_act = 0; m_ptr = 0; m_msg = '0;
         for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
      end else if ((!m_act || cyc > m_a) && req != '0) begin
         w = -1;
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         for (int i = 0; i < NREQ; i++)
            if (i != w && req[i]) begin
               wait_c[i]++;
               chk("starve", 32'(wait_c[i] < NREQ), 32'd1);
            end
         wait_c[w] = 0;
         m_own = w; m_gs = cyc + 1; m_s = cyc + 2; m_a = cyc + 2 + SEQ + 1 + H;
         m_msg = msg_id[w*MSGW +: MSGW];
         m_ptr = (w + 1) % NREQ;
         m_act = 1;
         glog.push_back(w);
      end
      @(posedge clk); #1;
      cyc++;
      in_win = m_act && cyc >= m_gs && cyc <= m_a;
      e_gnt  = in_win ? (NREQ'(1) << m_own) : '0;
      chk("gnt",     32'(gnt),     32'(e_gnt));
      chk("busy",    32'(busy),    32'(in_win));
      chk("dispres", 32'(dispres), 32'(in_win && cyc == m_s));
      chk("ack",     32'(ack),     32'((in_win && cyc == m_a) ? e_gnt : '0));
      chk("msg_sel", 32'(msg_sel), 32'(m_msg));
      if (dispres) begin n_disp++; last_disp = cyc; end
      for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
      // requester protocol: drop on ack, optionally re-raise a cycle later
      req   = req | rearm;
      rearm = auto_rearm ? ack : '0;
      req   = req & ~ack;
   endtask

   task automatic run_until_ack(input int lim, output int acyc, output logic [NREQ-1:0] aval);
      acyc = -1; aval = '0;
      for (int n = 0; n < lim; n++) begin
         step();
         if (ack != '0) begin acyc = cyc; aval = ack; break; end
      end
      if (acyc < 0) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (busy && n < 200) begin step(); n++; end
      chk("drain_idle", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   initial begin
      int t0, t1, a0, a3, acyc, d0;
      logic [NREQ-1:0] aval;
      int g2_before, n_d_before;
      for (int i = 0; i < NREQ; i++) begin wait_c[i] = 0; ack_cnt[i] = 0; end
      reset = 1'b1; req = '0; msg_id = '0; req0 = '0; msg_id0 = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_gnt",  32'(gnt),     32'd0);
      chk("rst_msg",  32'(msg_sel), 32'd0);
      chk("rst_busy", 32'(busy),    32'd0);
      step();

      // 1: single request
      msg_id[2*MSGW +: MSGW] = 4'd5; req = 4'b0100; t0 = cyc;
      step();
      chk("t1_gnt", 32'(gnt), 32'b0100);
      chk("t1_msg", 32'(msg_sel), 32'd5);
      n_d_before = n_disp;
      run_until_ack(100, acyc, aval);
      chk("t1_disp_cyc", 32'(last_disp - t0), 32'd2);
      chk("t1_ndisp",    32'(n_disp - n_d_before), 32'd1);
      chk("t1_ack_cyc",  32'(acyc - t0), 32'd44);
      chk("t1_ack_val",  32'(aval), 32'b0100);
      step();
      chk("t1_idle", 32'(busy), 32'd0);

      // 2: contention from pointer 0; next grant starts after one ARB cycle
      do_reset();
      req = 4'b1001;
      run_until_ack(100, a0, aval);
      chk("t2_first", 32'(aval), 32'b0001);
      run_until_ack(100, a3, aval);
      chk("t2_second", 32'(aval), 32'b1000);
      chk("t2_gap", 32'(a3 - a0), 32'(1 + 2 + SEQ + 1 + H));

      // 3: round robin with all requesters re-raising
      step();
      glog.delete();
      n_d_before = n_disp;
      auto_rearm = 1; req = 4'b1111;
      for (int n = 0; n < 400 && glog.size() < 5; n++) step();
      step(); step(); step();
      auto_rearm = 0; req = '0; rearm = '0;
      chk("t3_ngrants", 32'(glog.size()), 32'd5);
      if (glog.size() >= 5)
         for (int i = 0; i < 5; i++) chk("t3_order", 32'(glog[i]), 32'(i % NREQ));
      chk("t3_ndisp", 32'(n_disp - n_d_before), 32'd5);
      drain();
      step();

      // 4: msg_id change after grant ignored; requester 2 drops before grant
      g2_before = ack_cnt[2];
      glog.delete();
      msg_id[1*MSGW +: MSGW] = 4'd3; req = 4'b0010;
      step(); step();
      msg_id[1*MSGW +: MSGW] = 4'd9; req[2] = 1'b1;
      step(); step(); step();
      req[2] = 1'b0;
      run_until_ack(100, acyc, aval);
      chk("t4_ack",     32'(aval), 32'b0010);
      chk("t4_msg",     32'(msg_sel), 32'd3);
      for (int n = 0; n < 5; n++) step();
      chk("t4_no_ack2", 32'(ack_cnt[2] - g2_before), 32'd0);
      chk("t4_grants",  32'(glog.size()), 32'd1);

      // 5: reset during WRITE, then pointer is back at 0
      req = 4'b0100; t0 = cyc;
      for (int n = 0; n < 10; n++) step();
      reset = 1'b1; step(); reset = 1'b0;
      chk("t5_gnt",  32'(gnt),     32'd0);
      chk("t5_busy", 32'(busy),    32'd0);
      chk("t5_msg",  32'(msg_sel), 32'd0);
      chk("t5_disp", 32'(dispres), 32'd0);
      chk("t5_ack",  32'(ack),     32'd0);
      req = 4'b1100; t1 = cyc;
      step();
      chk("t5_regnt", 32'(gnt), 32'b0100);
      step();
      chk("t5_disp_lat", 32'(last_disp - t1), 32'd2);
      run_until_ack(100, acyc, aval);
      run_until_ack(100, acyc, aval);
      drain();

      // 6: zero hold time build
      msg_id0 = 16'h00A0; req0 = 4'b0010; t0 = cyc; d0 = -1; acyc = -1;
      for (int n = 0; n < 100 && acyc < 0; n++) begin
         step();
         if (dispres0) begin
            d0 = cyc;
            chk("t6_busy", 32'(busy0), 32'd1);
            chk("t6_gnt",  32'(gnt0),  32'b0010);
            chk("t6_msg",  32'(msg_sel0), 32'hA);
         end
         if (ack0 != '0) begin acyc = cyc; chk("t6_ackval", 32'(ack0), 32'b0010); req0 = '0; end
      end
      chk("t6_disp_lat", 32'(d0 - t0), 32'd2);
      chk("t6_ack_lat",  32'(acyc - d0), 32'd38);

      // random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 15) == 0) begin
               req[i] = 1'b1;
               msg_id[i*MSGW +: MSGW] = MSGW'($urandom);
            end else if (req[i] && $urandom_range(0, 99) == 0) begin
               req[i] = 1'b0;
            end
            if ($urandom_range(0, 31) == 0) msg_id[i*MSGW +: MSGW] = MSGW'($urandom);
         end
         reset = ($urandom_range(0, 599) == 0);
         step();
      end
      reset = 1'b0; req = '0;
      drain();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
